codec_cfg_arbiter: RTL and testbench

// - Shares the single codec I2C write engine between NREQ requesters, e.g. boot init, volume, sample-rate control.
// - Each request is one 16-bit codec register word: {reg_addr[6:0], reg_data[8:0]}.
// - Grants requesters round-robin and issues one engine transaction per grant.
// - Retries on NACK or timeout, then reports ack or err back to the requester.

---
 rtl/codec_cfg_arbiter.sv | 142 ++++++++++++++
 tb/tb_codec_cfg_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/codec_cfg_arbiter.sv
// codec_cfg_arbiter: round-robin arbiter sharing one codec I2C write engine.
// Issues one engine transaction per grant, retries failures, answers ack/err.
module codec_cfg_arbiter #(
  parameter int          NREQ      = 4,
  parameter logic [7:0]  DEV_ADDR  = 8'h34,
  parameter int          TIMEOUT   = 4096,
  parameter int          MAX_RETRY = 3,
  parameter int          RETRY_GAP = 64
) (
  input  logic                 clk_n,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   req_word,
  output logic [NREQ-1:0]      ack,
  output logic [NREQ-1:0]      err,
  output logic                 busy,
  output logic                 i2c_start,
  output logic [7:0]           i2c_dev,
  output logic [15:0]          i2c_word,
  input  logic                 i2c_done,
  input  logic                 i2c_nack
);

  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TMAX = (TIMEOUT > RETRY_GAP) ? TIMEOUT : RETRY_GAP;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int RW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  logic [2:0]    state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] grant;
  logic [RW-1:0] retry_cnt;
  logic [TW-1:0] timer;
  logic          ok;

  logic          pick_vld;
  logic [IW-1:0] pick;
  logic          fail;

  // Round-robin pick: first set req starting at rr_ptr, wrapping mod NREQ.
  always_comb begin
    logic [IW-1:0] idx;
    idx      = '0;
    pick_vld = 1'b0;
    pick     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IW'((int'(rr_ptr) + k) % NREQ);
      if (req[idx]) begin
        pick_vld = 1'b1;
        pick     = idx;
      end
    end
  end

  // A simultaneous done+nack is a NACK; timeout aborts on the last WAIT cycle.
  assign fail = i2c_nack || (timer == TW'(TIMEOUT - 1));

  // Main sequencer: grant, issue, wait, back off and respond.
  always_ff @(negedge clk_n) begin
    if (rst) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      grant     <= '0;
      retry_cnt <= '0;
      timer     <= '0;
      ok        <= 1'b0;
      i2c_word  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (pick_vld) begin
            grant     <= pick;
            i2c_word  <= req_word[16*pick +: 16];
            retry_cnt <= '0;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          timer <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (i2c_done && !i2c_nack) begin
            ok    <= 1'b1;
            state <= S_RESP;
          end else if (fail) begin
            timer <= '0;
            if (retry_cnt < RW'(MAX_RETRY)) begin
              retry_cnt <= retry_cnt + RW'(1);
              state     <= S_GAP;
            end else begin
              ok    <= 1'b0;
              state <= S_RESP;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_GAP: begin
          if (timer == TW'(RETRY_GAP - 1)) begin
            state <= S_ISSUE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_RESP: begin
          if (grant == IW'(NREQ - 1)) begin
            rr_ptr <= '0;
          end else begin
            rr_ptr <= grant + IW'(1);
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Response pulses come straight from the one-cycle RESP state.
  always_comb begin
    ack = '0;
    err = '0;
    if (state == S_RESP) begin
      if (ok) begin
        ack[grant] = 1'b1;
      end else begin
        err[grant] = 1'b1;
      end
    end
  end

  assign busy      = (state != S_IDLE);
  assign i2c_start = (state == S_ISSUE);
  assign i2c_dev   = DEV_ADDR;

endmodule

// File: tb/tb_codec_cfg_arbiter.sv
// tb_codec_cfg_arbiter: directed bench for codec_cfg_arbiter.
// Expected values are hand-derived constants.
module tb_codec_cfg_arbiter;

  localparam int TO  = 4096;
  localparam int GAP = 64;

  logic        clk_n = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] req_word;
  logic [3:0]  ack, err;
  logic        busy, i2c_start;
  logic [7:0]  i2c_dev;
  logic [15:0] i2c_word;
  logic        i2c_done, i2c_nack;

  logic [3:0]  b_req;
  logic [63:0] b_word;
  logic [3:0]  b_ack, b_err;
  logic        b_busy, b_start;
  logic [7:0]  b_dev;
  logic [15:0] b_i2c_word;
  logic        b_done, b_nack;

  int checks   = 0;
  int failures = 0;

  always #5 clk_n = ~clk_n;

  codec_cfg_arbiter #(
    .NREQ(4), .DEV_ADDR(8'h34), .TIMEOUT(TO),
    .MAX_RETRY(3), .RETRY_GAP(GAP)
  ) u0 (
    .clk_n(clk_n), .rst(rst), .req(req), .req_word(req_word),
    .ack(ack), .err(err), .busy(busy), .i2c_start(i2c_start),
    .i2c_dev(i2c_dev), .i2c_word(i2c_word),
    .i2c_done(i2c_done), .i2c_nack(i2c_nack)
  );

  codec_cfg_arbiter #(
    .NREQ(4), .DEV_ADDR(8'h1A), .TIMEOUT(TO),
    .MAX_RETRY(0), .RETRY_GAP(GAP)
  ) u1 (
    .clk_n(clk_n), .rst(rst), .req(b_req), .req_word(b_word),
    .ack(b_ack), .err(b_err), .busy(b_busy), .i2c_start(b_start),
    .i2c_dev(b_dev), .i2c_word(b_i2c_word),
    .i2c_done(b_done), .i2c_nack(b_nack)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_n);
    #1;
  endtask

  task automatic wait_start(input string tag, input int exp);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!i2c_start && n < exp + 10);
    chk(tag, 32'(n), 32'(exp));
  endtask

  initial begin
    int n;
    int starts;
    rst      = 1'b1;
    req      = '0;
    req_word = {16'h7A55, 16'h5C10, 16'h0E02, 16'h0123};
    i2c_done = 1'b0;
    i2c_nack = 1'b0;
    b_req    = '0;
    b_word   = {16'h0, 16'h0, 16'h0, 16'h1ABC};
    b_done   = 1'b0;
    b_nack   = 1'b0;

    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_ack",   32'(ack),       32'h0);
    chk("rst_err",   32'(err),       32'h0);
    chk("rst_busy",  32'(busy),      32'h0);
    chk("rst_start", 32'(i2c_start), 32'h0);
    chk("rst_word",  32'(i2c_word),  32'h0);
    chk("dev_addr",  32'(i2c_dev),   32'h34);

    // single request from requester 1
    req = 4'b0010;
    tick();
    chk("t1_start_lat", 32'(i2c_start), 32'h1);
    chk("t1_word",      32'(i2c_word),  32'h0E02);
    chk("t1_busy",      32'(busy),      32'h1);
    repeat (20) tick();
    chk("t1_no_early_ack", 32'(ack), 32'h0);
    i2c_done = 1'b1;
    tick();
    i2c_done = 1'b0;
    chk("t1_ack", 32'(ack), 32'h2);
    chk("t1_err", 32'(err), 32'h0);
    req = 4'b0000;
    tick();
    chk("t1_ack_once", 32'(ack),  32'h0);
    chk("t1_idle",     32'(busy), 32'h0);

    // all requesters held from reset: 0,1,2,3,0,1,2,3
    rst = 1'b1;
    req = 4'b1111;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wait_start("t2_lat", (i == 0) ? 1 : 2);
      chk("t2_word", 32'(i2c_word), 32'(req_word[16*(i%4) +: 16]));
      repeat (3) tick();
      i2c_done = 1'b1;
      tick();
      i2c_done = 1'b0;
      chk("t2_ack", 32'(ack), 32'(4'b0001 << (i % 4)));
      chk("t2_err", 32'(err), 32'h0);
    end
    req = 4'b0000;
    tick();

    // two NACKs then done on requester 2
    req = 4'b0100;
    wait_start("t3_lat", 1);
    for (int a = 0; a < 2; a++) begin
      repeat (3) tick();
      i2c_nack = 1'b1;
      tick();
      i2c_nack = 1'b0;
      chk("t3_no_err", 32'(err), 32'h0);
      wait_start("t3_gap", GAP);
      chk("t3_word", 32'(i2c_word), 32'h5C10);
    end
    repeat (3) tick();
    i2c_done = 1'b1;
    tick();
    i2c_done = 1'b0;
    chk("t3_ack", 32'(ack), 32'h4);
    chk("t3_err", 32'(err), 32'h0);
    req = 4'b0000;
    tick();

    // engine silent: four timed-out attempts then err on requester 3
    req = 4'b1000;
    wait_start("t4_lat", 1);
    for (int a = 0; a < 3; a++) begin
      wait_start("t4_retry", TO + GAP + 1);
    end
    n = 0;
    starts = 0;
    do begin
      tick();
      n++;
      if (i2c_start) starts++;
    end while (err == 4'b0000 && n < TO + 10);
    chk("t4_err_time", 32'(n),      32'(TO + 1));
    chk("t4_extra",    32'(starts), 32'h0);
    chk("t4_err",      32'(err),    32'h8);
    chk("t4_ack",      32'(ack),    32'h0);
    req = 4'b0000;
    tick();
    chk("t4_busy", 32'(busy), 32'h0);
    chk("t4_err_once", 32'(err), 32'h0);

    // reset in WAIT: rr_ptr returns to requester 0's turn
    req = 4'b0010;
    wait_start("t5_a_lat", 1);
    tick();
    i2c_done = 1'b1;
    tick();
    i2c_done = 1'b0;
    chk("t5_a_ack", 32'(ack), 32'h2);
    req = 4'b0000;
    tick();
    req = 4'b0110;
    wait_start("t5_pre_lat", 1);
    chk("t5_pre_word", 32'(i2c_word), 32'h5C10);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_busy",  32'(busy),      32'h0);
    chk("t5_rst_start", 32'(i2c_start), 32'h0);
    chk("t5_rst_word",  32'(i2c_word),  32'h0);
    chk("t5_rst_resp",  32'({ack, err}), 32'h0);
    wait_start("t5_post_lat", 1);
    chk("t5_post_word", 32'(i2c_word), 32'h0E02);
    repeat (2) tick();
    i2c_done = 1'b1;
    tick();
    i2c_done = 1'b0;
    chk("t5_post_ack", 32'(ack), 32'h2);
    req = 4'b0000;
    tick();

    // spurious done in IDLE on the main instance
    i2c_done = 1'b1;
    tick();
    i2c_done = 1'b0;
    chk("t6_idle_done_ack",  32'(ack),  32'h0);
    chk("t6_idle_done_busy", 32'(busy), 32'h0);

    // MAX_RETRY=0: done+nack together is a failure
    chk("t6_dev", 32'(b_dev), 32'h1A);
    b_req = 4'b0001;
    tick();
    chk("t6_start", 32'(b_start),    32'h1);
    chk("t6_word",  32'(b_i2c_word), 32'h1ABC);
    repeat (2) tick();
    b_done = 1'b1;
    b_nack = 1'b1;
    tick();
    b_done = 1'b0;
    b_nack = 1'b0;
    chk("t6_err", 32'(b_err), 32'h1);
    chk("t6_ack", 32'(b_ack), 32'h0);
    b_req = 4'b0000;
    tick();
    chk("t6_busy", 32'(b_busy), 32'h0);
    b_done = 1'b1;
    tick();
    b_done = 1'b0;
    chk("t6_spur_ack",  32'(b_ack),   32'h0);
    tick();
    chk("t6_spur_idle", 32'({b_busy, b_start, b_ack}), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
